// File: rtl/e203_itcm_pkg.sv
// Shared ITCM definitions: SRAM geometry, response word layout and power-state encoding.
package e203_itcm_pkg;

  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 64;
  localparam int unsigned MW    = 8;
  localparam int unsigned RSP_W = 33;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_SLEEP  = 2'd1,
    PWR_WAKE   = 2'd2
  } pwr_state_e;

endpackage

// File: rtl/e203_itcm_rsp_fifo.sv
// Two-entry response FIFO holding {err, rdata} words for the ITCM ICB bridge.
module e203_itcm_rsp_fifo
  import e203_itcm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [RSP_W-1:0] push_data,
  input  logic             pop,
  output logic [RSP_W-1:0] head_data,
  output logic [1:0]       count
);

  logic [RSP_W-1:0] mem [0:1];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/e203_itcm_icb_bridge.sv
// ICB to 64-bit ITCM SRAM bridge with in-order responses and idle-driven light sleep.
module e203_itcm_icb_bridge
  import e203_itcm_pkg::*;
#(
  parameter int unsigned IDLE_CNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic          icb_cmd_read,
  input  logic [15:0]   icb_cmd_addr,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [31:0]   icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls
);

  localparam logic [8:0] IDLE_LIM = 9'(IDLE_CNT);

  pwr_state_e       state;
  logic [7:0]       idle_cnt;
  logic [8:0]       idle_inc;
  logic             idle_now;

  logic             pend_valid;
  logic             pend_ram;
  logic             pend_read;
  logic             pend_lane;
  logic [RSP_W-1:0] pend_rsp;

  logic [1:0]       fifo_count;
  logic [RSP_W-1:0] fifo_head;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic [1:0]       inflight;
  logic             cmd_fire;
  logic             aligned;

  assign inflight      = fifo_count + {1'b0, pend_valid};
  assign icb_cmd_ready = ~rst & (state == PWR_ACTIVE) & (inflight < 2'd2);
  assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
  assign aligned       = (icb_cmd_addr[1:0] == 2'b00);

  assign ram_cs   = cmd_fire & aligned;
  assign ram_we   = ~icb_cmd_read;
  assign ram_addr = icb_cmd_addr[15:3];
  assign ram_din  = {2{icb_cmd_wdata}};
  assign ram_wem  = icb_cmd_addr[2] ? {icb_cmd_wmask, 4'b0000} : {4'b0000, icb_cmd_wmask};
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  // One-cycle command stage: SRAM data is only valid the cycle after cs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_ram   <= 1'b0;
      pend_read  <= 1'b0;
      pend_lane  <= 1'b0;
    end else begin
      pend_valid <= cmd_fire;
      pend_ram   <= aligned;
      pend_read  <= icb_cmd_read;
      pend_lane  <= icb_cmd_addr[2];
    end
  end

  always_comb begin
    pend_rsp = '0;
    if (!pend_ram)
      pend_rsp = {1'b1, 32'h0};
    else if (pend_read)
      pend_rsp = {1'b0, pend_lane ? ram_dout[63:32] : ram_dout[31:0]};
  end

  // Bypass the FIFO when it is empty; otherwise the stage result queues behind older responses.
  assign fifo_empty    = (fifo_count == 2'd0);
  assign fifo_pop      = ~fifo_empty & icb_rsp_ready;
  assign fifo_push     = pend_valid & ~(fifo_empty & icb_rsp_ready);
  assign icb_rsp_valid = pend_valid | ~fifo_empty;
  assign {icb_rsp_err, icb_rsp_rdata} = fifo_empty ? pend_rsp : fifo_head;

  e203_itcm_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (pend_rsp),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign idle_now = ~icb_cmd_valid & (inflight == 2'd0);
  assign idle_inc = {1'b0, idle_cnt} + 9'd1;

  // Sleep is entered on the edge where the idle count reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PWR_ACTIVE;
      idle_cnt <= '0;
      ram_ls   <= 1'b0;
    end else begin
      case (state)
        PWR_ACTIVE: begin
          if (!idle_now) begin
            idle_cnt <= '0;
          end else if (idle_inc >= IDLE_LIM) begin
            idle_cnt <= IDLE_LIM[7:0];
            state    <= PWR_SLEEP;
            ram_ls   <= 1'b1;
          end else begin
            idle_cnt <= idle_inc[7:0];
          end
        end
        PWR_SLEEP: begin
          if (icb_cmd_valid) begin
            state  <= PWR_WAKE;
            ram_ls <= 1'b0;
          end
        end
        PWR_WAKE: begin
          state    <= PWR_ACTIVE;
          idle_cnt <= '0;
          ram_ls   <= 1'b0;
        end
        default: begin
          state    <= PWR_ACTIVE;
          idle_cnt <= '0;
          ram_ls   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e203_itcm_icb_bridge.sv
// Directed and randomized bench for the ITCM ICB bridge against a word-level memory model.
module tb_e203_itcm_icb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [15:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        ram_cs;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din;
  logic [63:0] ram_dout;
  logic        ram_sd;
  logic        ram_ds;
  logic        ram_ls;

  int unsigned total = 0;
  int unsigned passed = 0;

  logic [63:0] sram [0:8191] = '{default: '0};
  logic [31:0] ref_mem [0:16383] = '{default: '0};
  logic [32:0] exp_q [$];
  logic [32:0] exp_front;

  always #5 clk = ~clk;

  e203_itcm_icb_bridge #(.IDLE_CNT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wem       (ram_wem),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_sd        (ram_sd),
    .ram_ds        (ram_ds),
    .ram_ls        (ram_ls)
  );

  // Behavioural SRAM: byte-enabled write, registered read data.
  always @(posedge clk) begin
    if (ram_cs) begin
      for (int b = 0; b < 8; b++)
        if (ram_we && ram_wem[b]) sram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      ram_dout <= sram[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic rd, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] wm);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
  endtask

  task automatic send(input logic rd, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] wm);
    int unsigned n = 0;
    set_cmd(rd, a, wd, wm);
    forever begin
      icb_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (icb_cmd_ready) break;
      n++;
      if (n > 30) begin
        check("cmd_timeout", 64'd0, 64'd1);
        break;
      end
      tick();
    end
    tick();
    icb_cmd_valid = 1'b0;
  endtask

  // Reference: expected response per accepted command, from a 32-bit word memory.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (icb_rsp_valid && icb_rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          exp_front = exp_q.pop_front();
          check("rsp_rdata", 64'(icb_rsp_rdata), 64'(exp_front[31:0]));
          check("rsp_err", 64'(icb_rsp_err), 64'(exp_front[32]));
        end
      end
      if (icb_cmd_valid && icb_cmd_ready) begin
        if (icb_cmd_addr[1:0] != 2'b00) begin
          exp_q.push_back({1'b1, 32'h0});
        end else if (icb_cmd_read) begin
          exp_q.push_back({1'b0, ref_mem[icb_cmd_addr[15:2]]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (icb_cmd_wmask[b]) ref_mem[icb_cmd_addr[15:2]][b*8 +: 8] = icb_cmd_wdata[b*8 +: 8];
          exp_q.push_back(33'h0);
        end
      end
      if (ram_cs) check("cs_gated", {62'd0, ram_ls, 1'b0} | 64'(icb_cmd_addr[1:0]), 64'd0);
    end
  end

  initial begin
    int unsigned n;
    logic [15:0] a;

    rst = 1'b1;
    icb_rsp_ready = 1'b1;
    set_cmd(1'b1, 16'h0000, 32'h0, 4'h0);
    tick();
    tick();
    @(negedge clk);
    check("rst_cmd_ready", 64'(icb_cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(icb_rsp_valid), 64'd0);
    check("rst_ram_cs", 64'(ram_cs), 64'd0);
    check("rst_ram_ls", 64'(ram_ls), 64'd0);
    check("sd_ds", {62'd0, ram_sd, ram_ds}, 64'd0);
    tick();
    rst = 1'b0;
    icb_cmd_valid = 1'b0;

    // Idle into light sleep, then wake on a read.
    n = 0;
    @(negedge clk);
    check("ready_after_rst", 64'(icb_cmd_ready), 64'd1);
    while (!ram_ls && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("idle_cycles_to_ls", 64'(n), 64'd16);
    check("sleep_not_ready", 64'(icb_cmd_ready), 64'd0);
    tick();
    set_cmd(1'b1, 16'h0000, 32'h0, 4'h0);
    @(negedge clk);
    check("sleep_ls", 64'(ram_ls), 64'd1);
    check("sleep_cs", 64'(ram_cs), 64'd0);
    @(negedge clk);
    check("wake_ls", 64'(ram_ls), 64'd0);
    check("wake_ready", 64'(icb_cmd_ready), 64'd0);
    check("wake_cs", 64'(ram_cs), 64'd0);
    @(negedge clk);
    check("active_ready", 64'(icb_cmd_ready), 64'd1);
    check("active_cs", 64'(ram_cs), 64'd1);
    tick();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("wake_rsp_valid", 64'(icb_rsp_valid), 64'd1);

    // Write lane 1 then read it back.
    tick();
    set_cmd(1'b0, 16'h0004, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("w_cs", 64'(ram_cs), 64'd1);
    check("w_we", 64'(ram_we), 64'd1);
    check("w_wem", 64'(ram_wem), 64'hF0);
    check("w_addr", 64'(ram_addr), 64'd0);
    check("w_din", ram_din, {2{32'hDEADBEEF}});
    tick();
    set_cmd(1'b1, 16'h0004, 32'h0, 4'h0);
    @(negedge clk);
    check("r_ready", 64'(icb_cmd_ready), 64'd1);
    tick();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("r_rsp_valid", 64'(icb_rsp_valid), 64'd1);
    check("r_rsp_rdata", 64'(icb_rsp_rdata), 64'hDEADBEEF);
    check("r_rsp_err", 64'(icb_rsp_err), 64'd0);

    // Back-to-back reads, responses in consecutive cycles.
    tick();
    set_cmd(1'b1, 16'h0000, 32'h0, 4'h0);
    @(negedge clk);
    check("b2b_ready0", 64'(icb_cmd_ready), 64'd1);
    check("b2b_rsp0_none", 64'(icb_rsp_valid), 64'd0);
    tick();
    set_cmd(1'b1, 16'h0004, 32'h0, 4'h0);
    @(negedge clk);
    check("b2b_ready1", 64'(icb_cmd_ready), 64'd1);
    check("b2b_rsp_t1", {31'd0, icb_rsp_valid, icb_rsp_rdata}, {31'd0, 1'b1, 32'h0});
    tick();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_rsp_t2", {31'd0, icb_rsp_valid, icb_rsp_rdata}, {31'd0, 1'b1, 32'hDEADBEEF});
    tick();
    @(negedge clk);
    check("b2b_drained", 64'(icb_rsp_valid), 64'd0);

    // Backpressure: third command stalls until a response pops.
    tick();
    icb_rsp_ready = 1'b0;
    set_cmd(1'b1, 16'h0000, 32'h0, 4'h0);
    @(negedge clk);
    check("bp_ready_a", 64'(icb_cmd_ready), 64'd1);
    tick();
    set_cmd(1'b1, 16'h0004, 32'h0, 4'h0);
    @(negedge clk);
    check("bp_ready_b", 64'(icb_cmd_ready), 64'd1);
    tick();
    set_cmd(1'b1, 16'h0008, 32'h0, 4'h0);
    @(negedge clk);
    check("bp_stall_c0", 64'(icb_cmd_ready), 64'd0);
    tick();
    @(negedge clk);
    check("bp_stall_c1", 64'(icb_cmd_ready), 64'd0);
    check("bp_head", {31'd0, icb_rsp_valid, icb_rsp_rdata}, {31'd0, 1'b1, 32'h0});
    tick();
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_stall_pop", 64'(icb_cmd_ready), 64'd0);
    tick();
    @(negedge clk);
    check("bp_ready_c", 64'(icb_cmd_ready), 64'd1);
    tick();
    icb_cmd_valid = 1'b0;

    // Misaligned write: no SRAM access, error response.
    tick();
    set_cmd(1'b0, 16'h0002, 32'h12345678, 4'hF);
    @(negedge clk);
    check("mis_ready", 64'(icb_cmd_ready), 64'd1);
    check("mis_cs", 64'(ram_cs), 64'd0);
    tick();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("mis_rsp", {30'd0, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}, {30'd0, 2'b11, 32'h0});

    // Randomized traffic, checked by the reference model.
    for (int i = 0; i < 80; i++) begin
      a = 16'($urandom_range(0, 15) * 8 + $urandom_range(0, 1) * 4);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    icb_rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two responses queued.
    tick();
    icb_rsp_ready = 1'b0;
    set_cmd(1'b1, 16'h0004, 32'h0, 4'h0);
    @(negedge clk);
    check("rq_ready_a", 64'(icb_cmd_ready), 64'd1);
    tick();
    set_cmd(1'b1, 16'h0000, 32'h0, 4'h0);
    @(negedge clk);
    check("rq_ready_b", 64'(icb_cmd_ready), 64'd1);
    tick();
    icb_cmd_valid = 1'b0;
    tick();
    @(negedge clk);
    check("rq_queued", {31'd0, icb_rsp_valid, 32'(exp_q.size())}, {31'd0, 1'b1, 32'd2});
    tick();
    rst = 1'b1;
    #1;
    check("rq_rst_rsp_valid", 64'(icb_rsp_valid), 64'd0);
    check("rq_rst_ready", 64'(icb_cmd_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    check("rq_ready_after", 64'(icb_cmd_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (icb_rsp_valid) n++;
      @(negedge clk);
    end
    check("rq_no_stale", 64'(n), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
